// File: rtl/requant_drain.sv
// East-edge drain: round-half-up shift, optional ReLU, saturate, then buffer in a credit-checked FIFO.
// Define REQUANT_STATS_EN to build the saturation event counter behind sat_count.
module requant_drain #(
   parameter int unsigned datawidth = 11,
   parameter int unsigned columns   = 64,
   parameter int unsigned depth     = 8,
   localparam int unsigned accwidth = 2*datawidth + $clog2(columns),
   localparam int unsigned cntw     = $clog2(depth) + 1
) (
   input  logic                   clk,
   input  logic                   rst_overall_n,
   input  logic [accwidth-1:0]    psum_in,
   input  logic                   psum_valid,
   output logic                   psum_ready,
   input  logic [4:0]             shift_amt,
   input  logic                   relu_en,
   output logic [datawidth-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [cntw-1:0]        fifo_count,
   output logic                   drop_flag,
   output logic [15:0]            sat_count
);

   localparam int unsigned ptrw = $clog2(depth);
   localparam logic signed [accwidth:0] sat_max =
      {{(accwidth+2-datawidth){1'b0}}, {(datawidth-1){1'b1}}};
   localparam logic signed [accwidth:0] sat_min =
      {{(accwidth+2-datawidth){1'b1}}, {(datawidth-1){1'b0}}};

   logic                        accept;
   logic                        s1_valid;
   logic signed [accwidth-1:0]  s1_psum;
   logic [4:0]                  s1_shift;
   logic                        s1_relu;
   logic [accwidth:0]           s1_half;
   logic signed [accwidth:0]    s1_sum;
   logic signed [accwidth:0]    s1_r;

   logic                        s2_valid;
   logic signed [accwidth:0]    s2_r;
   logic                        s2_relu;
   logic                        s2_neg;
   logic                        s2_hi;
   logic                        s2_lo;
   logic [datawidth-1:0]        s2_res;

   logic [datawidth-1:0]        mem [depth];
   logic [ptrw-1:0]             wr_ptr;
   logic [ptrw-1:0]             rd_ptr;
   logic                        push;
   logic                        pop;
   logic [cntw:0]               inflight;

   // Credit counts everything already committed downstream, so S2 never meets a full FIFO.
   always_comb begin
      inflight   = {1'b0, fifo_count} + (cntw+1)'(s1_valid) + (cntw+1)'(s2_valid);
      psum_ready = inflight < (cntw+1)'(depth);
   end

   assign accept = psum_valid && psum_ready;

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n) begin
         s1_valid <= 1'b0;
         s1_psum  <= '0;
         s1_shift <= '0;
         s1_relu  <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_psum  <= psum_in;
            s1_shift <= shift_amt;
            s1_relu  <= relu_en;
         end
      end
   end

   // One extra bit of headroom keeps the rounding add from wrapping.
   always_comb begin
      s1_half = '0;
      if (s1_shift != '0)
         s1_half = (accwidth+1)'(1) << (s1_shift - 5'd1);
      s1_sum = $signed({s1_psum[accwidth-1], s1_psum}) + $signed(s1_half);
      s1_r   = s1_sum >>> s1_shift;
   end

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n) begin
         s2_valid <= 1'b0;
         s2_r     <= '0;
         s2_relu  <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_r    <= s1_r;
            s2_relu <= s1_relu;
         end
      end
   end

   always_comb begin
      s2_neg = s2_r[accwidth];
      s2_hi  = s2_r > sat_max;
      s2_lo  = s2_r < sat_min;
      if (s2_relu && s2_neg)
         s2_res = '0;
      else if (s2_hi)
         s2_res = {1'b0, {(datawidth-1){1'b1}}};
      else if (s2_lo)
         s2_res = {1'b1, {(datawidth-1){1'b0}}};
      else
         s2_res = s2_r[datawidth-1:0];
   end

   assign push = s2_valid;
   assign pop  = out_ready && (fifo_count != '0);

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int unsigned i = 0; i < depth; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= s2_res;
            wr_ptr      <= wr_ptr + ptrw'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + ptrw'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + cntw'(1);
            2'b01:   fifo_count <= fifo_count - cntw'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign out_data  = mem[rd_ptr];
   assign out_valid = fifo_count != '0;

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n)
         drop_flag <= 1'b0;
      else if (psum_valid && !psum_ready)
         drop_flag <= 1'b1;
   end

`ifdef REQUANT_STATS_EN
   logic sat_hit;
   assign sat_hit = s2_valid && !(s2_relu && s2_neg) && (s2_hi || s2_lo);

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n)
         sat_count <= '0;
      else if (sat_hit && (sat_count != 16'hFFFF))
         sat_count <= sat_count + 16'd1;
   end
`else
   assign sat_count = '0;
`endif

endmodule
